// File: rtl/r3_sdf_stage_ctrl_pkg.sv
// Shared types and helpers for the radix-3 SDF stage controller and its phase counter.
package r3_sdf_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic BF_PASS = 1'b0;
   localparam logic BF_BFLY = 1'b1;

   // Output phase k of the sample leaving the stage, given the input phase.
   function automatic logic [1:0] out_phase(input logic [1:0] phase);
      case (phase)
         2'd0:    return 2'd1;
         2'd1:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   function automatic int unsigned tw_exp(input logic [1:0] k, input int unsigned idx);
      return 32'(k) * idx;
   endfunction

endpackage

// File: rtl/r3_sdf_stage_ctrl_if.sv
// Handshake and datapath-control bundle between the input source, the controller and the stage datapath.
interface r3_sdf_stage_ctrl_if #(
   parameter int DELAY = 3
);
   localparam int TW_W = (2 * DELAY - 1 > 1) ? $clog2(2 * DELAY - 1) : 1;

   logic            in_valid;
   logic            in_sof;
   logic            flush;
   logic            in_ready;
   logic            en;
   logic            dl_we;
   logic            bf_sel;
   logic [TW_W-1:0] tw_addr;
   logic            out_valid;
   logic            out_sof;
   logic            err_sof;

   modport master (
      output in_valid, in_sof, flush,
      input  in_ready, en, dl_we, bf_sel, tw_addr, out_valid, out_sof, err_sof
   );

   modport slave (
      input  in_valid, in_sof, flush,
      output in_ready, en, dl_we, bf_sel, tw_addr, out_valid, out_sof, err_sof
   );
endinterface

// File: rtl/r3_sdf_stage_ctrl_phase_counter.sv
// idx/phase position counter for a 3*DELAY frame with enable, sync restart and clear.
// R3_CTRL_NEGEDGE_EN selects negedge clocking of the flops.
module r3_sdf_stage_ctrl_phase_counter #(
   parameter  int DELAY = 3,
   localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic             clr,
   output logic [CNT_W-1:0] idx,
   output logic [1:0]       phase,
   output logic             at_start
);
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(DELAY - 1);

   logic [CNT_W-1:0] idx_reg, idx_next;
   logic [1:0]       phase_reg, phase_next;

   // A restarting sample is itself position idx0/phase0, so the visible position is forced to zero.
   assign idx      = restart ? '0 : idx_reg;
   assign phase    = restart ? 2'd0 : phase_reg;
   assign at_start = (idx_reg == '0) && (phase_reg == 2'd0);

   always_comb begin
      idx_next   = idx_reg;
      phase_next = phase_reg;
      if (clr) begin
         idx_next   = '0;
         phase_next = 2'd0;
      end else if (en) begin
         if (idx == IDX_LAST) begin
            idx_next   = '0;
            phase_next = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
         end else begin
            idx_next   = idx + 1'b1;
            phase_next = phase;
         end
      end else if (restart) begin
         idx_next   = '0;
         phase_next = 2'd0;
      end
   end

`ifdef R3_CTRL_NEGEDGE_EN
   always_ff @(negedge clk or negedge rst_n) begin
`else
   always_ff @(posedge clk or negedge rst_n) begin
`endif
      if (!rst_n) begin
         idx_reg   <= '0;
         phase_reg <= 2'd0;
      end else begin
         idx_reg   <= idx_next;
         phase_reg <= phase_next;
      end
   end

endmodule

// File: rtl/r3_sdf_stage_ctrl.sv
// Sequencer for one radix-3 SDF FFT stage: enables, butterfly select, twiddle address, output framing.
// R3_CTRL_NEGEDGE_EN selects negedge clocking of all controller flops.
module r3_sdf_stage_ctrl
   import r3_sdf_stage_ctrl_pkg::*;
#(
   parameter int DELAY = 3
) (
   input logic               clk,
   input logic               rst_n,
   r3_sdf_stage_ctrl_if.slave bus
);
   localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam int TW_W  = (2 * DELAY - 1 > 1) ? $clog2(2 * DELAY - 1) : 1;
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(DELAY - 1);

   state_t           state_reg, state_next;
   logic             flush_pend_reg, flush_pend_next;
   logic             err_sof_reg, err_sof_next;

   logic [CNT_W-1:0] idx;
   logic [1:0]       phase;
   logic             at_start;
   logic             in_frame;
   logic             start_req;
   logic             misplaced;
   logic             restart;
   logic             clr;
   logic             enable;
   logic             out_valid;
   logic             out_sof;
   logic             frame_end;
   logic             flush_end;

   assign in_frame  = (state_reg == FILL) || (state_reg == RUN);
   assign start_req = bus.in_valid && bus.in_sof;
   assign misplaced = start_req && in_frame && !at_start;
   assign restart   = (start_req && (state_reg == IDLE)) || misplaced;
   assign frame_end = (phase == 2'd2) && (idx == IDX_LAST);
   assign flush_end = (phase == 2'd1) && (idx == IDX_LAST);

   r3_sdf_stage_ctrl_phase_counter #(
      .DELAY (DELAY)
   ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (enable),
      .restart  (restart),
      .clr      (clr),
      .idx      (idx),
      .phase    (phase),
      .at_start (at_start)
   );

   always_comb begin
      state_next      = state_reg;
      flush_pend_next = flush_pend_reg;
      err_sof_next    = 1'b0;
      enable          = 1'b0;
      clr             = 1'b0;
      out_valid       = 1'b0;
      out_sof         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_req) begin
               enable     = 1'b1;
               state_next = FILL;
            end
         end
         FILL, RUN: begin
            enable = bus.in_valid;
            if (misplaced) begin
               // Resync: delay-line contents are stale, so refill before emitting anything.
               err_sof_next    = 1'b1;
               flush_pend_next = 1'b0;
               state_next      = FILL;
            end else begin
               out_valid = (state_reg == RUN) ? enable : (enable && (phase == 2'd2));
               out_sof   = enable && (phase == 2'd2) && (idx == '0);
               if (enable && bus.flush) flush_pend_next = 1'b1;
               if (enable && frame_end) begin
                  if (flush_pend_reg || bus.flush) begin
                     state_next      = FLUSH;
                     flush_pend_next = 1'b0;
                  end else begin
                     state_next = RUN;
                  end
               end
            end
         end
         FLUSH: begin
            enable    = 1'b1;
            out_valid = 1'b1;
            if (flush_end) begin
               clr        = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef R3_CTRL_NEGEDGE_EN
   always_ff @(negedge clk or negedge rst_n) begin
`else
   always_ff @(posedge clk or negedge rst_n) begin
`endif
      if (!rst_n) begin
         state_reg      <= IDLE;
         flush_pend_reg <= 1'b0;
         err_sof_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         flush_pend_reg <= flush_pend_next;
         err_sof_reg    <= err_sof_next;
      end
   end

   assign bus.in_ready  = (state_reg != FLUSH);
   assign bus.en        = enable;
   assign bus.dl_we     = enable;
   assign bus.bf_sel    = ((state_reg != FLUSH) && (phase == 2'd2)) ? BF_BFLY : BF_PASS;
   assign bus.tw_addr   = TW_W'(tw_exp(out_phase(phase), 32'(idx)));
   assign bus.out_valid = out_valid;
   assign bus.out_sof   = out_sof;
   assign bus.err_sof   = err_sof_reg;

endmodule
